// File: rtl/lau_pkg.sv
// Shared definitions for the lau arithmetic units: adder/prefix speed grades
// and the requester-index width helper used by shared (arbitrated) units.
package lau_pkg;

   typedef enum logic [1:0] {
      SLOW   = 2'd0,
      MEDIUM = 2'd1,
      FAST   = 2'd2
   } speed_e;

   // Block size of the bypass structure used by the MEDIUM grade.
   localparam int NegBlk = 4;

   function automatic int idx_width(int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/Neg.sv
// Two's-complement negator: z = -a mod 2^width. Bit i of -a is a[i] xor
// (any lower bit of a set), so the datapath is a prefix-OR whose shape follows speed.
module Neg import lau_pkg::*; #(
   parameter int     width = 8,
   parameter speed_e speed = FAST
) (
   input  logic [width-1:0] a_i,
   output logic [width-1:0] z_o
);

   logic [width-1:0] pre;

   if (speed == SLOW) begin : g_slow
      logic run;
      always_comb begin
         run = 1'b0;
         pre = '0;
         for (int i = 0; i < width; i++) begin
            pre[i] = run;
            run    = run | a_i[i];
         end
      end
   end else if (speed == MEDIUM) begin : g_medium
      // Ripple inside each block, block-level OR forwarded to the next block.
      logic run;
      logic blk_in;
      logic blk_acc;
      always_comb begin
         run     = 1'b0;
         blk_in  = 1'b0;
         blk_acc = 1'b0;
         pre     = '0;
         for (int i = 0; i < width; i++) begin
            if (i % NegBlk == 0) begin
               run     = blk_in;
               blk_acc = 1'b0;
            end
            pre[i]  = run;
            run     = run | a_i[i];
            blk_acc = blk_acc | a_i[i];
            if ((i % NegBlk == NegBlk - 1) || (i == width - 1)) begin
               blk_in = blk_in | blk_acc;
            end
         end
      end
   end else begin : g_fast
      // Kogge-Stone prefix OR: log2(width) levels of doubling span.
      localparam int Levels = $clog2(width);
      logic [width-1:0] lvl [Levels+1];
      always_comb begin
         lvl[0] = a_i;
         for (int k = 1; k <= Levels; k++) begin
            lvl[k] = lvl[k-1] | (lvl[k-1] << (1 << (k - 1)));
         end
      end
      assign pre = lvl[Levels] << 1;
   end

   assign z_o = a_i ^ pre;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests upward from a priority pointer with
// wrap-around; the pointer moves past the winner only when en_i (handshake) is set.
module rr_arbiter import lau_pkg::*; #(
   parameter  int NumReq  = 4,
   localparam int IdWidth = idx_width(NumReq)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NumReq-1:0]  req_i,
   input  logic               en_i,
   output logic [NumReq-1:0]  gnt_o,
   output logic [IdWidth-1:0] idx_o
);

   logic [IdWidth-1:0] ptr_q;
   logic [IdWidth-1:0] ptr_d;
   logic               found;
   int                 j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NumReq; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NumReq) j = j - NumReq;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IdWidth'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (en_i) begin
         ptr_d = (idx_o == IdWidth'(NumReq - 1)) ? '0 : idx_o + IdWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/neg_arbiter.sv
// Shared negation unit: round-robin arbitration of NumReq requesters onto one
// Neg instance, result registered with requester ID and overflow flag.
module neg_arbiter import lau_pkg::*; #(
   parameter  int     width   = 8,
   parameter  speed_e speed   = FAST,
   parameter  int     NumReq  = 4,
   localparam int     IdWidth = idx_width(NumReq)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumReq-1:0]       req_valid_i,
   output logic [NumReq-1:0]       req_ready_o,
   input  logic [NumReq*width-1:0] req_op_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [width-1:0]        rsp_z_o,
   output logic [IdWidth-1:0]      rsp_id_o,
   output logic                    rsp_ovf_o
);

   // Handshakes: a request completes on req_valid_i[i] & req_ready_o[i], a
   // response on rsp_valid_o & rsp_ready_i. Ready may look at valid, never the reverse.

   localparam logic [width-1:0] MinVal = {1'b1, {(width-1){1'b0}}};

   logic [NumReq-1:0]  gnt;
   logic [IdWidth-1:0] gnt_idx;
   logic               can_accept;
   logic               req_fire;
   logic [width-1:0]   op_sel;
   logic [width-1:0]   neg_z;

   logic               rsp_valid_q, rsp_valid_d;
   logic [width-1:0]   rsp_z_q,     rsp_z_d;
   logic [IdWidth-1:0] rsp_id_q,    rsp_id_d;
   logic               rsp_ovf_q,   rsp_ovf_d;

   rr_arbiter #(.NumReq(NumReq)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (req_valid_i),
      .en_i   (req_fire),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx)
   );

   assign can_accept  = !rsp_valid_q || rsp_ready_i;
   assign req_ready_o = gnt & {NumReq{can_accept & rst_ni}};
   assign req_fire    = |req_ready_o;

   always_comb begin
      op_sel = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (gnt[i]) op_sel = op_sel | req_op_i[i*width +: width];
      end
   end

   Neg #(.width(width), .speed(speed)) u_neg (
      .a_i (op_sel),
      .z_o (neg_z)
   );

   // A new result overrides a drain in the same cycle, so valid stays high.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_z_d     = rsp_z_q;
      rsp_id_d    = rsp_id_q;
      rsp_ovf_d   = rsp_ovf_q;
      if (req_fire) begin
         rsp_valid_d = 1'b1;
         rsp_z_d     = neg_z;
         rsp_id_d    = gnt_idx;
         rsp_ovf_d   = (op_sel == MinVal);
      end else if (rsp_valid_q && rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_z_q     <= '0;
         rsp_id_q    <= '0;
         rsp_ovf_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_z_q     <= rsp_z_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ovf_q   <= rsp_ovf_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_z_o     = rsp_z_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_ovf_o   = rsp_ovf_q;

endmodule

// File: tb/tb_neg_arbiter.sv
// Bench for neg_arbiter: FAST, MEDIUM and SLOW instances share one stimulus
// stream and are checked against a cycle model with an expected-result queue.
module tb_neg_arbiter;
   import lau_pkg::*;

   localparam int NDut = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_op;
   logic        rsp_ready;

   logic [3:0]  rdy_w [NDut];
   logic        vld_w [NDut];
   logic [7:0]  z_w   [NDut];
   logic [1:0]  id_w  [NDut];
   logic        ovf_w [NDut];

   for (genvar g = 0; g < NDut; g++) begin : gen_dut
      localparam speed_e Sp = (g == 0) ? FAST : ((g == 1) ? MEDIUM : SLOW);
      neg_arbiter #(.width(8), .speed(Sp), .NumReq(4)) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .req_valid_i (req_valid),
         .req_ready_o (rdy_w[g]),
         .req_op_i    (req_op),
         .rsp_valid_o (vld_w[g]),
         .rsp_ready_i (rsp_ready),
         .rsp_z_o     (z_w[g]),
         .rsp_id_o    (id_w[g]),
         .rsp_ovf_o   (ovf_w[g])
      );
   end

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   int          pass_cnt = 0;
   int          tot_cnt  = 0;
   logic [10:0] exp_q [$];   // {id[1:0], ovf, z[7:0]}
   logic        m_valid;
   int          m_ptr;
   logic [3:0]  m_hs;
   int          wait_cnt [4];
   int          max_wait;

   typedef struct packed {
      logic [3:0]  vld;
      logic [31:0] ops;
      logic [3:0]  gnt;
      logic [7:0]  z;
      logic [1:0]  id;
      logic        ovf;
      logic [1:0]  ptr;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
   endtask

   function automatic logic [3:0] model_gnt(input int p, input logic [3:0] v);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
      end
      return 4'b0;
   endfunction

   task automatic chk_ptr(input string name, input logic [1:0] exp);
      chk(name, 0, 32'(gen_dut[0].u_dut.u_arb.ptr_q), 32'(exp));
      chk(name, 1, 32'(gen_dut[1].u_dut.u_arb.ptr_q), 32'(exp));
      chk(name, 2, 32'(gen_dut[2].u_dut.u_arb.ptr_q), 32'(exp));
   endtask

   task automatic chk_rsp(input string name, input logic v, input logic [7:0] z,
                          input logic [1:0] id, input logic ovf);
      for (int k = 0; k < NDut; k++) begin
         chk({name, "_valid"}, k, 32'(vld_w[k]), 32'(v));
         chk({name, "_z"},     k, 32'(z_w[k]),   32'(z));
         chk({name, "_id"},    k, 32'(id_w[k]),  32'(id));
         chk({name, "_ovf"},   k, 32'(ovf_w[k]), 32'(ovf));
      end
   endtask

   task automatic chk_rdy(input string name, input logic [3:0] exp);
      for (int k = 0; k < NDut; k++) chk(name, k, 32'(rdy_w[k]), 32'(exp));
   endtask

   // One clock: compare against the model at negedge, advance the model at posedge.
   task automatic cycle();
      logic [3:0]  eg;
      logic        rsp_hs;
      logic [10:0] e;
      logic [7:0]  op;
      int          g;
      @(negedge clk);
      eg = (rst_n && (!m_valid || rsp_ready)) ? model_gnt(m_ptr, req_valid) : 4'b0;
      for (int k = 0; k < NDut; k++) begin
         chk("req_ready", k, 32'(rdy_w[k]), 32'(eg));
         chk("rsp_valid", k, 32'(vld_w[k]), 32'(m_valid));
         if (m_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("sb_z",   k, 32'(z_w[k]),   32'(e[7:0]));
            chk("sb_ovf", k, 32'(ovf_w[k]), 32'(e[8]));
            chk("sb_id",  k, 32'(id_w[k]),  32'(e[10:9]));
         end
      end
      m_hs   = eg;
      rsp_hs = rst_n && m_valid && rsp_ready;
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         m_valid = 1'b0;
         m_ptr   = 0;
         for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end else begin
         if (rsp_hs && exp_q.size() > 0) void'(exp_q.pop_front());
         if (|eg) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) g = i;
            op = req_op[g*8 +: 8];
            exp_q.push_back({2'(g), op == 8'h80, 8'(8'h00 - op)});
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
            for (int i = 0; i < 4; i++) begin
               if (i == g) begin
                  if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                  wait_cnt[i] = 0;
               end else if (req_valid[i]) begin
                  wait_cnt[i]++;
               end
            end
         end else if (rsp_hs) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_op = '0; rsp_ready = 1'b0;
      m_valid = 1'b0; m_ptr = 0; m_hs = '0; max_wait = 0;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

      //          vld      ops           gnt      z      id  ovf  ptr
      tbl[0]  = '{4'b0010, 32'h00000500, 4'b0010, 8'hFB, 2'd1, 1'b0, 2'd2};
      tbl[1]  = '{4'b0001, 32'h00000000, 4'b0001, 8'h00, 2'd0, 1'b0, 2'd1};
      tbl[2]  = '{4'b0001, 32'h00000080, 4'b0001, 8'h80, 2'd0, 1'b1, 2'd1};
      tbl[3]  = '{4'b0001, 32'h000000FF, 4'b0001, 8'h01, 2'd0, 1'b0, 2'd1};
      tbl[4]  = '{4'b1000, 32'h7F000000, 4'b1000, 8'h81, 2'd3, 1'b0, 2'd0};
      tbl[5]  = '{4'b1111, 32'h807F0201, 4'b0001, 8'hFF, 2'd0, 1'b0, 2'd1};
      tbl[6]  = '{4'b1111, 32'h807F0201, 4'b0010, 8'hFE, 2'd1, 1'b0, 2'd2};
      tbl[7]  = '{4'b1111, 32'h807F0201, 4'b0100, 8'h81, 2'd2, 1'b0, 2'd3};
      tbl[8]  = '{4'b1111, 32'h807F0201, 4'b1000, 8'h80, 2'd3, 1'b1, 2'd0};
      tbl[9]  = '{4'b1111, 32'h807F0201, 4'b0001, 8'hFF, 2'd0, 1'b0, 2'd1};
      tbl[10] = '{4'b0100, 32'h00100000, 4'b0100, 8'hF0, 2'd2, 1'b0, 2'd3};
      tbl[11] = '{4'b1001, 32'h33000044, 4'b1000, 8'hCD, 2'd3, 1'b0, 2'd0};
      tbl[12] = '{4'b1001, 32'h33000044, 4'b0001, 8'hBC, 2'd0, 1'b0, 2'd1};

      // Reset values
      repeat (2) cycle();
      rst_n = 1'b1;
      chk_rsp("reset", 1'b0, 8'h00, 2'd0, 1'b0);
      chk_ptr("reset_ptr", 2'd0);

      // Table: one request per cycle, consumer always ready
      rsp_ready = 1'b1;
      for (int t = 0; t < 13; t++) begin
         req_valid = tbl[t].vld;
         req_op    = tbl[t].ops;
         #1;
         chk_rdy($sformatf("tbl%0d_gnt", t), tbl[t].gnt);
         cycle();
         chk_rsp($sformatf("tbl%0d", t), 1'b1, tbl[t].z, tbl[t].id, tbl[t].ovf);
         chk_ptr($sformatf("tbl%0d_ptr", t), tbl[t].ptr);
      end

      // Backpressure: hold for 3 cycles, then drain and reload together
      req_valid = 4'b0010; req_op = 32'h00001100;
      cycle();
      chk_rsp("bp_load", 1'b1, 8'hEF, 2'd1, 1'b0);
      rsp_ready = 1'b0; req_valid = 4'b1111; req_op = 32'h90A0B0C0;
      for (int t = 0; t < 3; t++) begin
         #1;
         chk_rdy("bp_stall_rdy", 4'b0000);
         cycle();
         chk_rsp("bp_hold", 1'b1, 8'hEF, 2'd1, 1'b0);
         chk_ptr("bp_ptr", 2'd2);
      end
      rsp_ready = 1'b1;
      #1;
      chk_rdy("bp_release_rdy", 4'b0100);
      cycle();
      chk_rsp("bp_reload", 1'b1, 8'h60, 2'd2, 1'b0);
      chk_ptr("bp_reload_ptr", 2'd3);

      // Reset while full with requesters valid
      rst_n = 1'b0;
      #1;
      chk_rdy("rst_rdy", 4'b0000);
      cycle();
      chk_rsp("rst_mid", 1'b0, 8'h00, 2'd0, 1'b0);
      chk_ptr("rst_mid_ptr", 2'd0);
      rst_n = 1'b1; req_valid = 4'b0000;
      cycle();
      for (int k = 0; k < NDut; k++) chk("rst_no_hs", k, 32'(vld_w[k]), 32'd0);

      // Random traffic; requesters hold valid/operand until their handshake
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      max_wait = 0;
      m_hs = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (m_hs[i] || !req_valid[i]) begin
               if ($urandom_range(0, 99) < 60) begin
                  req_valid[i] = 1'b1;
                  case ($urandom_range(0, 7))
                     0:       req_op[i*8 +: 8] = 8'h80;
                     1:       req_op[i*8 +: 8] = 8'h00;
                     2:       req_op[i*8 +: 8] = 8'hFF;
                     default: req_op[i*8 +: 8] = 8'($urandom_range(0, 255));
                  endcase
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      chk("fair_max_wait_le_3", 0, 32'(max_wait <= 3), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
